// File: rtl/shared_access_arbiter.sv
// Round-robin arbiter time-sharing one target state machine among NUM_CLIENTS requesters.
// Optional WAIT_FINISH timeout enabled by defining SHARED_ACCESS_TIMEOUT_EN.
module shared_access_arbiter #(
    parameter int NUM_CLIENTS    = 4,
    parameter int ARG_W          = 32,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 255,
    localparam int GID_W         = $clog2(NUM_CLIENTS)
) (
    input  logic                          sm_clk,
    input  logic                          reset,
    input  logic [NUM_CLIENTS-1:0]        start_request,
    input  logic [NUM_CLIENTS*ARG_W-1:0]  input_arguments,
    output logic [NUM_CLIENTS-1:0]        reset_start_request,
    output logic [NUM_CLIENTS-1:0]        finish,
    output logic [NUM_CLIENTS*DATA_W-1:0] received_data,
    output logic [ARG_W-1:0]              output_arguments,
    output logic                          start_target_state_machine,
    input  logic                          target_state_machine_finished,
    input  logic [DATA_W-1:0]             in_received_data,
    output logic [GID_W-1:0]              grant_id,
    output logic                          busy,
    output logic                          timeout_error
);

    // state           | meaning
    // S_IDLE          | no transaction; arbitrate among raised requests
    // S_GIVE_START    | pulse target start and clear granted client's request
    // S_WAIT_FINISH   | wait for target finished (or timeout when enabled)
    // S_REGISTER_DATA | capture target data into granted client's slot
    // S_GIVE_FINISH   | pulse granted client's finish, advance RR pointer
    typedef enum logic [2:0] {
        S_IDLE,
        S_GIVE_START,
        S_WAIT_FINISH,
        S_REGISTER_DATA,
        S_GIVE_FINISH
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [GID_W-1:0]  r_grant_id;
    logic [GID_W-1:0]  r_ptr;
    logic [DATA_W-1:0] r_slot [NUM_CLIENTS];
    logic [ARG_W-1:0]  w_args [NUM_CLIENTS];
    logic              w_req_found;
    logic [GID_W-1:0]  w_req_idx;
    logic [NUM_CLIENTS-1:0] w_grant_onehot;
    logic              w_timeout_hit;

    for (genvar gi = 0; gi < NUM_CLIENTS; gi++) begin : g_slots
        assign w_args[gi] = input_arguments[gi*ARG_W +: ARG_W];
        assign received_data[gi*DATA_W +: DATA_W] = r_slot[gi];
    end

    assign output_arguments = w_args[r_grant_id];
    assign grant_id         = r_grant_id;
    assign w_grant_onehot   = {{(NUM_CLIENTS-1){1'b0}}, 1'b1} << r_grant_id;

    // Scan ptr+1, ptr+2, ... so the last served client has lowest priority.
    always_comb begin
        int               v_idx;
        logic [GID_W-1:0] v_cand;
        w_req_found = 1'b0;
        w_req_idx   = '0;
        v_idx       = 0;
        v_cand      = '0;
        for (int k = 1; k <= NUM_CLIENTS; k++) begin
            v_idx  = (int'(r_ptr) + k) % NUM_CLIENTS;
            v_cand = GID_W'(v_idx);
            if (!w_req_found && start_request[v_cand]) begin
                w_req_found = 1'b1;
                w_req_idx   = v_cand;
            end
        end
    end

`ifdef SHARED_ACCESS_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] r_to_cnt;
    logic            r_to_flag;

    assign w_timeout_hit = (r_to_cnt == '0);
    assign timeout_error = (r_state == S_GIVE_FINISH) && r_to_flag;

    always_ff @(posedge sm_clk or posedge reset) begin
        if (reset) begin
            r_to_cnt  <= '0;
            r_to_flag <= 1'b0;
        end else begin
            if (r_state == S_GIVE_START)
                r_to_cnt <= TO_W'(TIMEOUT_CYCLES - 1);
            else if (r_state == S_WAIT_FINISH && r_to_cnt != '0)
                r_to_cnt <= r_to_cnt - 1'b1;
            r_to_flag <= (r_state == S_WAIT_FINISH) && !target_state_machine_finished
                         && w_timeout_hit;
        end
    end
`else
    assign w_timeout_hit = 1'b0;
    assign timeout_error = 1'b0;
`endif

    always_comb begin
        w_state_nxt                = r_state;
        start_target_state_machine = 1'b0;
        reset_start_request        = '0;
        finish                     = '0;
        busy                       = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (w_req_found)
                    w_state_nxt = S_GIVE_START;
            end
            S_GIVE_START: begin
                start_target_state_machine = 1'b1;
                reset_start_request        = w_grant_onehot;
                w_state_nxt                = S_WAIT_FINISH;
            end
            S_WAIT_FINISH: begin
                if (target_state_machine_finished)
                    w_state_nxt = S_REGISTER_DATA;
                else if (w_timeout_hit)
                    w_state_nxt = S_GIVE_FINISH;
            end
            S_REGISTER_DATA: begin
                w_state_nxt = S_GIVE_FINISH;
            end
            S_GIVE_FINISH: begin
                finish      = w_grant_onehot;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge sm_clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_grant_id <= '0;
            r_ptr      <= GID_W'(NUM_CLIENTS - 1);
            for (int i = 0; i < NUM_CLIENTS; i++)
                r_slot[i] <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && w_req_found)
                r_grant_id <= w_req_idx;
            if (r_state == S_REGISTER_DATA)
                r_slot[r_grant_id] <= in_received_data;
            if (r_state == S_GIVE_FINISH)
                r_ptr <= r_grant_id;
        end
    end

endmodule

// File: tb/tb_shared_access_arbiter.sv
// Self-checking bench for shared_access_arbiter: directed scenarios plus randomized
// transactions against a distance-based round-robin reference model.
module tb_shared_access_arbiter;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 8;
    localparam int TO = 8;
    localparam int GW = $clog2(N);

    logic              sm_clk = 1'b0;
    logic              reset;
    logic [N-1:0]      start_request;
    logic [N*AW-1:0]   input_arguments;
    logic [N-1:0]      reset_start_request;
    logic [N-1:0]      finish;
    logic [N*DW-1:0]   received_data;
    logic [AW-1:0]     output_arguments;
    logic              start_target_state_machine;
    logic              target_state_machine_finished;
    logic [DW-1:0]     in_received_data;
    logic [GW-1:0]     grant_id;
    logic              busy;
    logic              timeout_error;

    int total = 0;
    int bad   = 0;
    int ptr_m;
    logic [DW-1:0] slot_m [N];

    shared_access_arbiter #(
        .NUM_CLIENTS(N), .ARG_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .sm_clk(sm_clk),
        .reset(reset),
        .start_request(start_request),
        .input_arguments(input_arguments),
        .reset_start_request(reset_start_request),
        .finish(finish),
        .received_data(received_data),
        .output_arguments(output_arguments),
        .start_target_state_machine(start_target_state_machine),
        .target_state_machine_finished(target_state_machine_finished),
        .in_received_data(in_received_data),
        .grant_id(grant_id),
        .busy(busy),
        .timeout_error(timeout_error)
    );

    always #5 sm_clk = ~sm_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sm_clk);
        #1;
    endtask

    // Winner is the requester with the smallest forward distance from ptr+1.
    function automatic int pick(input logic [N-1:0] req, input int ptr);
        int best, bestd, d;
        best  = -1;
        bestd = N;
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                d = (i - ptr - 1 + 2*N) % N;
                if (d < bestd) begin
                    bestd = d;
                    best  = i;
                end
            end
        end
        return best;
    endfunction

    function automatic logic [N*DW-1:0] slots_packed();
        logic [N*DW-1:0] v;
        for (int i = 0; i < N; i++) v[i*DW +: DW] = slot_m[i];
        return v;
    endfunction

    task automatic model_reset();
        ptr_m = N - 1;
        for (int i = 0; i < N; i++) slot_m[i] = '0;
    endtask

    // Called in an IDLE cycle with at least one request raised; returns in the next IDLE cycle.
    task automatic serve(input int w, input logic [DW-1:0] d, input bit hold_req,
                         input bit fin_early, input bit churn);
        int g;
        logic [AW-1:0] a;
        g = pick(start_request, ptr_m);
        chk("idle_busy", busy, 0);
        if (fin_early) target_state_machine_finished = 1'b1;
        tick();
        a = input_arguments[g*AW +: AW];
        chk("gs_start", start_target_state_machine, 1);
        chk("gs_rsr", reset_start_request, 64'(1) << g);
        chk("gs_grant", grant_id, g);
        chk("gs_args", output_arguments, a);
        chk("gs_busy", busy, 1);
        chk("gs_finish", finish, 0);
        if (!hold_req) start_request[g] = 1'b0;
        tick();
        chk("wf_start", start_target_state_machine, 0);
        chk("wf_rsr", reset_start_request, 0);
        if (!fin_early) begin
            for (int i = 1; i < w; i++) begin
                target_state_machine_finished = 1'b0;
                tick();
                chk("wf_finish", finish, 0);
                chk("wf_busy", busy, 1);
            end
            target_state_machine_finished = 1'b1;
        end
        in_received_data = d;
        tick();
        target_state_machine_finished = 1'b0;
        chk("rd_finish", finish, 0);
        chk("rd_busy", busy, 1);
        if (churn) start_request = start_request ^ N'($urandom);
        tick();
        slot_m[g] = d;
        ptr_m = g;
        chk("gf_finish", finish, 64'(1) << g);
        chk("gf_slots", received_data, slots_packed());
        chk("gf_args", output_arguments, a);
        chk("gf_timeout", timeout_error, 0);
        in_received_data = DW'($urandom);
        tick();
        chk("end_finish", finish, 0);
        chk("end_busy", busy, 0);
    endtask

    initial begin
        reset = 1'b1;
        start_request = '0;
        target_state_machine_finished = 1'b0;
        in_received_data = '0;
        for (int i = 0; i < N; i++) input_arguments[i*AW +: AW] = $urandom;
        model_reset();
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_start", start_target_state_machine, 0);
        chk("rst_finish", finish, 0);
        chk("rst_rsr", reset_start_request, 0);
        chk("rst_grant", grant_id, 0);
        chk("rst_slots", received_data, 0);
        chk("rst_timeout", timeout_error, 0);
        reset = 1'b0;
        tick();

        // single request from client 2
        start_request = 4'b0100;
        serve(3, 8'hA5, 0, 0, 0);
        chk("t1_slot2", received_data, {8'h00, 8'hA5, 8'h00, 8'h00});

        // argument routing for clients 3 then 1
        input_arguments[1*AW +: AW] = 32'hDEADBEEF;
        input_arguments[3*AW +: AW] = 32'h12345678;
        start_request = 4'b1010;
        serve(2, 8'h3C, 0, 0, 0);
        chk("t6_args3", output_arguments, 32'h12345678);
        serve(1, 8'h5A, 0, 0, 0);
        chk("t6_args1", output_arguments, 32'hDEADBEEF);

        // reset during WAIT_FINISH
        start_request = 4'b1000;
        tick();
        start_request = '0;
        tick();
        #2 reset = 1'b1;
        #1;
        model_reset();
        chk("t4_busy", busy, 0);
        chk("t4_start", start_target_state_machine, 0);
        chk("t4_finish", finish, 0);
        chk("t4_slots", received_data, 0);
        chk("t4_grant", grant_id, 0);
        tick();
        chk("t4_hold_finish", finish, 0);
        reset = 1'b0;
        tick();

        // continuous all-client load rotates 0,1,2,3,0
        start_request = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            serve(1 + i % 3, DW'(8'h10 + i), 1, 0, 0);
            chk("t2_rr_order", grant_id, i % N);
        end
        start_request = '0;

        // finished held high from reset
        reset = 1'b1;
        target_state_machine_finished = 1'b1;
        #3;
        model_reset();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3_idle_busy", busy, 0);
            chk("t3_idle_start", start_target_state_machine, 0);
        end
        start_request = 4'b0010;
        serve(1, 8'h77, 0, 1, 0);

`ifdef SHARED_ACCESS_TIMEOUT_EN
        start_request = 4'b0001;
        tick();
        chk("to_start", start_target_state_machine, 1);
        start_request = '0;
        for (int i = 0; i < TO; i++) begin
            tick();
            chk("to_wait_busy", busy, 1);
            chk("to_wait_finish", finish, 0);
            chk("to_wait_err", timeout_error, 0);
        end
        tick();
        ptr_m = 0;
        chk("to_finish", finish, 4'b0001);
        chk("to_err", timeout_error, 1);
        chk("to_slots", received_data, slots_packed());
        tick();
        chk("to_err_clear", timeout_error, 0);
        chk("to_idle", busy, 0);
`else
        start_request = 4'b0001;
        serve(12, 8'hC3, 0, 0, 0);
`endif

        // randomized traffic
        for (int n = 0; n < 40; n++) begin
            if (start_request == '0) start_request = N'($urandom_range(1, (1 << N) - 1));
            if ($urandom_range(0, 3) == 0)
                input_arguments[$urandom_range(0, N-1)*AW +: AW] = $urandom;
            serve($urandom_range(1, 4), DW'($urandom), 1'($urandom_range(0, 1)), 0, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
